// File: rtl/aw_burst_queue_pkg.sv
// aw_burst_queue_pkg
//   Shared widths, AXI3 burst encodings, generator state encoding, the queue
//   entry layout and the per-beat address helpers used by the AW front end.
package aw_burst_queue_pkg;

    localparam int ADD_ID_WIDTH = 4;   // AWID width
    localparam int ADD_WIDTH    = 32;  // address width
    localparam int BURST_LEN    = 4;   // AWLEN width (1-16 beats)
    localparam int BURST_SIZE   = 3;   // AWSIZE width
    localparam int BURST_TYPE   = 2;   // AWBURST width
    localparam int QUEUE_DEPTH  = 4;   // default queue depth

    localparam logic [ADD_WIDTH-1:0] ADDR_ONE = 1;

    typedef enum logic [BURST_TYPE-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } gen_state_e;

    typedef struct packed {
        logic [ADD_ID_WIDTH-1:0] id;
        logic [ADD_WIDTH-1:0]    addr;
        logic [BURST_LEN-1:0]    len;
        logic [BURST_SIZE-1:0]   size;
        burst_e                  burst;
    } aw_entry_t;

    localparam int ENTRY_W = ADD_ID_WIDTH + ADD_WIDTH + BURST_LEN + BURST_SIZE + BURST_TYPE;

    // Reserved type, or a WRAP whose beat count is not 2/4/8/16
    // (len+1 must be a power of two greater than one).
    function automatic logic burst_illegal(input burst_e b, input logic [BURST_LEN-1:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len != '0) && ((len & (len + BURST_LEN'(1))) == '0);
        return (b == BURST_RSVD) || ((b == BURST_WRAP) && !wrap_len_ok);
    endfunction

    // Address of the beat following addr. Callers pass the effective type,
    // so illegal bursts arrive here already demoted to INCR.
    function automatic logic [ADD_WIDTH-1:0] next_addr(
        input logic [ADD_WIDTH-1:0]  addr,
        input logic [BURST_SIZE-1:0] size,
        input logic [BURST_LEN-1:0]  len,
        input burst_e                b
    );
        logic [ADD_WIDTH-1:0] bytes, aligned, incr, wsize, lower;
        bytes   = ADDR_ONE << size;
        aligned = addr & ~(bytes - ADDR_ONE);
        incr    = aligned + bytes;
        wsize   = bytes * (ADD_WIDTH'(len) + ADDR_ONE);
        lower   = addr & ~(wsize - ADDR_ONE);
        case (b)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (incr == lower + wsize) ? lower : incr;
            default:     return incr;
        endcase
    endfunction

endpackage

// File: rtl/aw_burst_queue_if.sv
// aw_burst_queue_if
//   AW channel plus the per-beat address stream towards the write-data module.
//   slave  : the queue block (accepts AW, produces beats)
//   master : the environment (drives AW, consumes beats)
interface aw_burst_queue_if;
    import aw_burst_queue_pkg::*;

    logic [ADD_ID_WIDTH-1:0] awid;
    logic [ADD_WIDTH-1:0]    awaddr;
    logic [BURST_LEN-1:0]    awlen;
    logic [BURST_SIZE-1:0]   awsize;
    logic [BURST_TYPE-1:0]   awburst;
    logic [1:0]              awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;

    logic [ADD_WIDTH-1:0]    beat_addr;
    logic [ADD_ID_WIDTH-1:0] beat_id;
    logic [BURST_SIZE-1:0]   beat_size;
    logic                    beat_last;
    logic                    beat_valid;
    logic                    beat_ready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        output beat_addr, beat_id, beat_size, beat_last, beat_valid,
        input  beat_ready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        input  beat_addr, beat_id, beat_size, beat_last, beat_valid,
        output beat_ready
    );

endinterface

// File: rtl/aw_fifo.sv
// aw_fifo
//   DEPTH x W synchronous FIFO, show-ahead read (rdata is the head entry).
//   Ports: clk, reset (async, active high), push/wdata, pop/rdata,
//          count, count_next (value count takes at the next edge), full, empty.
//   A push into a full FIFO is taken when a pop happens in the same cycle.
module aw_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (do_push) wptr <= wptr + PW'(1);
            if (do_pop)  rptr <= rptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/aw_burst_queue.sv
// aw_burst_queue
//   AXI3 write-address front end. AW handshakes are queued (DEPTH entries) and
//   each queued burst is expanded into one address per data beat.
//   Ports:
//     clk, reset   - single clock, async active-high reset
//     bus (slave)  - AW channel in, beat_addr/id/size/last/valid out, beat_ready in
//     queue_count  - bursts queued and not yet started
//     burst_err    - high in the cycle an illegal burst is loaded (popped);
//                    that burst is then walked as INCR
module aw_burst_queue
    import aw_burst_queue_pkg::*;
#(
    parameter  int DEPTH = QUEUE_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    aw_burst_queue_if.slave   bus,
    output logic [CNT_W-1:0]  queue_count,
    output logic              burst_err
);

    aw_entry_t        push_entry, head;
    logic             push, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] cnt_next;
    logic             awready_q;

    gen_state_e            state, state_nxt;
    logic                  advance;
    logic [ADD_WIDTH-1:0]  cur_addr;
    logic [ADD_ID_WIDTH-1:0] cur_id;
    logic [BURST_SIZE-1:0] cur_size;
    logic [BURST_LEN-1:0]  cur_len;
    logic [BURST_LEN-1:0]  remaining;
    burst_e                cur_type;

    // Lock/cache/prot are accepted but have no effect on a plain memory slave.
    logic unused_aw_attr;
    assign unused_aw_attr = ^{bus.awlock, bus.awcache, bus.awprot, fifo_full};

    assign push_entry = '{id:    bus.awid,
                          addr:  bus.awaddr,
                          len:   bus.awlen,
                          size:  bus.awsize,
                          burst: burst_e'(bus.awburst)};
    assign push = bus.awvalid && bus.awready;

    aw_fifo #(.W(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wdata      (push_entry),
        .pop        (pop),
        .rdata      (head),
        .count      (queue_count),
        .count_next (cnt_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Registered ready: looks at the occupancy after this edge, so it falls
    // the cycle after the queue fills and rises again the cycle after a pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) awready_q <= 1'b0;
        else       awready_q <= (cnt_next < CNT_W'(DEPTH));
    end
    assign bus.awready = awready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next burst is popped either from IDLE or on the last-beat handshake,
    // so consecutive bursts run without a bubble.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (bus.beat_ready) begin
                    if (remaining == '0) begin
                        if (!fifo_empty) pop       = 1'b1;
                        else             state_nxt = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        burst_err = pop && burst_illegal(head.burst, head.len);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr  <= '0;
            cur_id    <= '0;
            cur_size  <= '0;
            cur_len   <= '0;
            remaining <= '0;
            cur_type  <= BURST_FIXED;
        end else if (pop) begin
            cur_addr  <= head.addr;
            cur_id    <= head.id;
            cur_size  <= head.size;
            cur_len   <= head.len;
            remaining <= head.len;
            cur_type  <= burst_illegal(head.burst, head.len) ? BURST_INCR : head.burst;
        end else if (advance) begin
            cur_addr  <= next_addr(cur_addr, cur_size, cur_len, cur_type);
            remaining <= remaining - BURST_LEN'(1);
        end
    end

    assign bus.beat_valid = (state == ST_BURST);
    assign bus.beat_last  = (state == ST_BURST) && (remaining == '0);
    assign bus.beat_addr  = cur_addr;
    assign bus.beat_id    = cur_id;
    assign bus.beat_size  = cur_size;

endmodule
